debounce_repeat: RTL and testbench

DEBOUNCE_REPEAT -- requirements
Module: debounce_repeat

---
 rtl/debounce_repeat_pkg.sv | 19 +
 rtl/debounce_repeat_core.sv | 41 ++++
 rtl/debounce_repeat.sv | 112 +++++++++++
 tb/tb_debounce_repeat.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debounce_repeat_pkg.sv
// Shared definitions for the game-input blocks: hold FSM encoding and default
// timing constants (cycle counts at 100 MHz).
package debounce_repeat_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } hold_state_e;

   localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
   localparam int unsigned DEF_LONG_CYC     = 50_000_000;
   localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_repeat_core.sv
// Two-flop synchronizer plus stability counter; pb_debounced follows the
// synchronized level only after DEBOUNCE_CYC consecutive differing cycles.
module debounce_core
   import debounce_repeat_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_raw,
   output logic pb_debounced
);

   localparam int unsigned     CW     = $clog2(DEBOUNCE_CYC);
   localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         cnt          <= '0;
         pb_debounced <= 1'b0;
      end else begin
         sync1 <= pb_raw;
         sync2 <= sync1;
         if (sync2 == pb_debounced) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            pb_debounced <= sync2;
            cnt          <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/debounce_repeat.sv
// Debounced push-button with press/release strobes and long-hold auto-repeat.
// The hold FSM tracks IDLE -> PRESSED -> REPEAT and returns to IDLE on release.
module debounce_repeat
   import debounce_repeat_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
   parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_raw,
   output logic pb_debounced,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic long_hold
);

   localparam int unsigned   HW      = $clog2(max_u(LONG_CYC, REPEAT_CYC));
   localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CYC - 1);

   hold_state_e   state;
   hold_state_e   state_nx;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_cnt_nx;
   logic          rep_q;
   logic          rep_nx;
   logic          deb_q;
   logic          press_evt;
   logic          rel_evt;

   debounce_core #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .pb_raw       (pb_raw),
      .pb_debounced (pb_debounced)
   );

   // Accepted edges are decoded from pb_debounced and its delayed copy, so the
   // strobes coincide with the debounced transition itself.
   assign press_evt = pb_debounced & ~deb_q;
   assign rel_evt   = ~pb_debounced & deb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q    <= 1'b0;
         state    <= IDLE;
         hold_cnt <= '0;
         rep_q    <= 1'b0;
      end else begin
         deb_q    <= pb_debounced;
         state    <= state_nx;
         hold_cnt <= hold_cnt_nx;
         rep_q    <= rep_nx;
      end
   end

   // The FSM observes a press one cycle after the press edge, so the hold
   // counter starts at 1; a release landing on a terminal-count edge is
   // suppressed at the outputs by gating with pb_debounced.
   always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      rep_nx      = 1'b0;
      case (state)
         IDLE: begin
            hold_cnt_nx = '0;
            if (press_evt) begin
               state_nx    = PRESSED;
               hold_cnt_nx = HW'(1);
            end
         end
         PRESSED: begin
            if (rel_evt) begin
               state_nx    = IDLE;
               hold_cnt_nx = '0;
            end else if (hold_cnt == LONG_TC) begin
               state_nx    = REPEAT;
               rep_nx      = 1'b1;
               hold_cnt_nx = '0;
            end else begin
               hold_cnt_nx = hold_cnt + HW'(1);
            end
         end
         REPEAT: begin
            if (rel_evt) begin
               state_nx    = IDLE;
               hold_cnt_nx = '0;
            end else if (hold_cnt == REP_TC) begin
               rep_nx      = 1'b1;
               hold_cnt_nx = '0;
            end else begin
               hold_cnt_nx = hold_cnt + HW'(1);
            end
         end
         default: begin
            state_nx    = IDLE;
            hold_cnt_nx = '0;
         end
      endcase
   end

   assign press_pulse   = press_evt;
   assign release_pulse = rel_evt;
   assign repeat_pulse  = rep_q & pb_debounced;
   assign long_hold     = (state == REPEAT) & pb_debounced;

endmodule

// File: tb/tb_debounce_repeat.sv
// Directed bench for debounce_repeat with DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.
// Output vectors are packed as {pb_debounced, press, release, repeat, long_hold}.
module tb_debounce_repeat;

   logic clk;
   logic rst_n;
   logic pb_raw;
   logic pb_debounced;
   logic press_pulse;
   logic release_pulse;
   logic repeat_pulse;
   logic long_hold;

   int unsigned checks;
   int unsigned errors;
   int unsigned edge_n;

   debounce_repeat #(
      .DEBOUNCE_CYC (4),
      .LONG_CYC     (20),
      .REPEAT_CYC   (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pb_raw        (pb_raw),
      .pb_debounced  (pb_debounced),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse),
      .long_hold     (long_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          fresh;
      int unsigned first;
      int unsigned last;
      logic        pb;
      logic [4:0]  exp;
      string       name;
   } seg_t;

   localparam int unsigned NSEG = 23;
   seg_t tbl [NSEG];

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic check(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {pb_debounced, press_pulse, release_pulse, repeat_pulse, long_hold};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d: got %b expected %b", name, edge_n, act, exp);
      end
   endtask

   // Reset is released 1 time unit after an edge, so the next edge is edge 1.
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      edge_n = 0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      pb_raw = 1'b0;
      rst_n  = 1'b0;

      // clean press, long hold with repeats, release landing after a repeat
      tbl[0]  = '{1'b1,  1,  9, 1'b0, 5'b00000, "clean_idle"};
      tbl[1]  = '{1'b0, 10, 14, 1'b1, 5'b00000, "clean_wait"};
      tbl[2]  = '{1'b0, 15, 15, 1'b1, 5'b11000, "clean_press"};
      tbl[3]  = '{1'b0, 16, 34, 1'b1, 5'b10000, "pressed_hold"};
      tbl[4]  = '{1'b0, 35, 35, 1'b1, 5'b10011, "long_entry"};
      tbl[5]  = '{1'b0, 36, 39, 1'b1, 5'b10001, "long_gap1"};
      tbl[6]  = '{1'b0, 40, 40, 1'b1, 5'b10011, "repeat_40"};
      tbl[7]  = '{1'b0, 41, 44, 1'b1, 5'b10001, "long_gap2"};
      tbl[8]  = '{1'b0, 45, 45, 1'b1, 5'b10011, "repeat_45"};
      tbl[9]  = '{1'b0, 46, 46, 1'b1, 5'b10001, "long_gap3"};
      tbl[10] = '{1'b0, 47, 49, 1'b0, 5'b10001, "rel_debounce"};
      tbl[11] = '{1'b0, 50, 50, 1'b0, 5'b10011, "repeat_50"};
      tbl[12] = '{1'b0, 51, 51, 1'b0, 5'b10001, "long_gap4"};
      tbl[13] = '{1'b0, 52, 52, 1'b0, 5'b00100, "release"};
      tbl[14] = '{1'b0, 53, 60, 1'b0, 5'b00000, "after_release"};
      // bounce: 1,0,1,0 then settle high at edge 9
      tbl[15] = '{1'b1,  1,  4, 1'b0, 5'b00000, "bounce_idle"};
      tbl[16] = '{1'b0,  5,  5, 1'b1, 5'b00000, "bounce_1"};
      tbl[17] = '{1'b0,  6,  6, 1'b0, 5'b00000, "bounce_0"};
      tbl[18] = '{1'b0,  7,  7, 1'b1, 5'b00000, "bounce_1b"};
      tbl[19] = '{1'b0,  8,  8, 1'b0, 5'b00000, "bounce_0b"};
      tbl[20] = '{1'b0,  9, 13, 1'b1, 5'b00000, "bounce_settle"};
      tbl[21] = '{1'b0, 14, 14, 1'b1, 5'b11000, "bounce_press"};
      tbl[22] = '{1'b0, 15, 18, 1'b1, 5'b10000, "bounce_held"};

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 5'b00000);

      for (int s = 0; s < NSEG; s++) begin
         if (tbl[s].fresh) begin
            pb_raw = 1'b0;
            do_reset();
         end
         for (int unsigned e = tbl[s].first; e <= tbl[s].last; e++) begin
            pb_raw = tbl[s].pb;
            tick();
            check(tbl[s].name, tbl[s].exp);
         end
      end

      // release collides with a repeat terminal count at edge 40
      pb_raw = 1'b0;
      do_reset();
      for (int e = 1; e <= 50; e++) begin
         pb_raw = (e >= 10 && e < 35);
         tick();
         if (e == 15)      check("coll_press", 5'b11000);
         else if (e == 35) check("coll_long", 5'b10011);
         else if (e == 40) check("coll_release", 5'b00100);
         else if (e > 40)  check("coll_idle", 5'b00000);
      end

      // reset asserted mid-hold with the button still down
      pb_raw = 1'b0;
      do_reset();
      for (int e = 1; e <= 37; e++) begin
         pb_raw = (e >= 10);
         tick();
         if (e == 15) check("rst_hold_press", 5'b11000);
         if (e == 37) check("rst_hold_long", 5'b10001);
      end
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", 5'b00000);
      for (int e = 0; e < 3; e++) begin
         tick();
         check("rst_held", 5'b00000);
      end
      rst_n  = 1'b1;
      edge_n = 0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e < 6)       check("rst_repress_wait", 5'b00000);
         else if (e == 6) check("rst_repress", 5'b11000);
         else             check("rst_repress_held", 5'b10000);
      end

      // short press: accepted at 15, release accepted at 30
      pb_raw = 1'b0;
      do_reset();
      for (int e = 1; e <= 40; e++) begin
         pb_raw = (e >= 10 && e < 25);
         tick();
         if (e == 15)                check("short_press", 5'b11000);
         else if (e == 30)           check("short_release", 5'b00100);
         else if (e > 15 && e < 30)  check("short_held", 5'b10000);
         else                        check("short_idle", 5'b00000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
